cache_line_store: RTL and testbench

- Parametrised cache data array: 2**ADDR_BITS lines of LINE_BITS each.
- Takes CPU word writes with a generalised word select.
- Takes RAM line refills as a multi-beat burst. A fill sequencer assembles the beats and commits the whole line atomically.
- Sits between the cache controller (hit path and CPU port) and the RAM interface (miss refill).

---
 rtl/cache_line_store.sv | 97 +++++++++
 tb/tb_cache_line_store.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/cache_line_store.sv
// cache_line_store: cache data array with CPU word writes and an atomic multi-beat line refill.
// The refill is assembled in a line buffer and committed to the array in a single edge.
module cache_line_store #(
    parameter int ADDR_BITS = 10,
    parameter int LINE_BITS = 64,
    parameter int WORD_BITS = 16,
    parameter int BEAT_BITS = 16,
    localparam int WPL = LINE_BITS / WORD_BITS,
    localparam int WSEL_BITS = (WPL > 1) ? $clog2(WPL) : 1,
    localparam int NBEATS = LINE_BITS / BEAT_BITS,
    localparam int CNT_BITS = (NBEATS > 1) ? $clog2(NBEATS) : 1
) (
    input  logic                 clk,
    input  logic                 gen_reset_n,
    input  logic                 cpu_we_i,
    input  logic                 cpu_re_i,
    input  logic [ADDR_BITS-1:0] cpu_addr_i,
    input  logic [WSEL_BITS-1:0] cpu_word_sel_i,
    input  logic [WORD_BITS-1:0] cpu_wdata_i,
    output logic [LINE_BITS-1:0] cpu_rdata_o,
    output logic                 cpu_rvalid_o,
    input  logic                 fill_start_i,
    input  logic [ADDR_BITS-1:0] fill_addr_i,
    input  logic                 fill_valid_i,
    input  logic [BEAT_BITS-1:0] fill_data_i,
    output logic                 fill_busy_o,
    output logic                 fill_done_o
);
    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;
    state_t               state_q, state_d;
    logic [CNT_BITS-1:0]  cnt_q, cnt_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [LINE_BITS-1:0] buf_q, buf_d;
    logic [LINE_BITS-1:0] mem_q [2**ADDR_BITS];
    logic [LINE_BITS-1:0] rdata_q;
    logic                 rvalid_q;
    logic [LINE_BITS-1:0] fill_line, wr_line;
    logic                 commit, wr_en;
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        buf_d     = buf_q;
        commit    = 1'b0;
        fill_line = buf_q;
        fill_line[cnt_q*BEAT_BITS +: BEAT_BITS] = fill_data_i;
        case (state_q)
            IDLE: if (fill_start_i) begin
                addr_d  = fill_addr_i;
                cnt_d   = '0;
                state_d = FILL;
            end
            FILL: if (fill_valid_i) begin
                buf_d = fill_line;
                if (cnt_q == CNT_BITS'(NBEATS - 1)) begin
                    commit  = 1'b1;
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    // Writes to the line being refilled are dropped: the commit would overwrite them anyway.
    always_comb begin
        wr_line = mem_q[cpu_addr_i];
        wr_line[cpu_word_sel_i*WORD_BITS +: WORD_BITS] = cpu_wdata_i;
        wr_en = cpu_we_i && (32'(cpu_word_sel_i) < WPL)
             && !(state_q == FILL && cpu_addr_i == addr_q);
    end
    always_ff @(posedge clk) begin
        if (!gen_reset_n) begin
            for (int i = 0; i < 2**ADDR_BITS; i++) mem_q[i] <= '0;
            state_q  <= IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            buf_q    <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            buf_q    <= buf_d;
            rvalid_q <= cpu_re_i;
            if (cpu_re_i) rdata_q <= mem_q[cpu_addr_i];
            if (wr_en) mem_q[cpu_addr_i] <= wr_line;
            if (commit) mem_q[addr_q] <= fill_line;
        end
    end
    assign cpu_rdata_o  = rdata_q;
    assign cpu_rvalid_o = rvalid_q;
    assign fill_busy_o  = (state_q != IDLE);
    assign fill_done_o  = (state_q == DONE);
endmodule

// File: tb/tb_cache_line_store.sv
// tb_cache_line_store: scoreboard bench for cache_line_store reads, word writes and refills.
module tb_cache_line_store;
    logic        clk = 1'b0;
    logic        gen_reset_n = 1'b0;
    logic        cpu_we = 1'b0, cpu_re = 1'b0;
    logic [9:0]  cpu_addr = '0;
    logic [1:0]  cpu_word_sel = '0;
    logic [15:0] cpu_wdata = '0;
    logic [63:0] cpu_rdata;
    logic        cpu_rvalid;
    logic        fill_start = 1'b0;
    logic [9:0]  fill_addr = '0;
    logic        fill_valid = 1'b0;
    logic [15:0] fill_data = '0;
    logic        fill_busy, fill_done;
    logic [63:0] sb [$];
    int checks = 0, errors = 0, done_cnt = 0;

    cache_line_store dut (
        .clk(clk), .gen_reset_n(gen_reset_n),
        .cpu_we_i(cpu_we), .cpu_re_i(cpu_re), .cpu_addr_i(cpu_addr),
        .cpu_word_sel_i(cpu_word_sel), .cpu_wdata_i(cpu_wdata),
        .cpu_rdata_o(cpu_rdata), .cpu_rvalid_o(cpu_rvalid),
        .fill_start_i(fill_start), .fill_addr_i(fill_addr),
        .fill_valid_i(fill_valid), .fill_data_i(fill_data),
        .fill_busy_o(fill_busy), .fill_done_o(fill_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (gen_reset_n && fill_done) done_cnt++;
        if (gen_reset_n && cpu_rvalid) begin
            if (sb.size() == 0) chk("rvalid_spurious", 64'd1, 64'd0);
            else chk("rdata", cpu_rdata, sb.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [9:0] a, input logic [63:0] e);
        cpu_re = 1'b1;
        cpu_addr = a;
        sb.push_back(e);
        tick();
        cpu_re = 1'b0;
    endtask

    task automatic wr(input logic [9:0] a, input logic [1:0] s, input logic [15:0] d);
        cpu_we = 1'b1;
        cpu_addr = a;
        cpu_word_sel = s;
        cpu_wdata = d;
        tick();
        cpu_we = 1'b0;
    endtask

    task automatic fstep(input logic v, input logic [15:0] d, input logic exp_done);
        fill_valid = v;
        fill_data = d;
        tick();
        fill_valid = 1'b0;
        chk("fill_busy", 64'(fill_busy), 64'd1);
        chk("fill_done", 64'(fill_done), 64'(exp_done));
    endtask

    task automatic start(input logic [9:0] a);
        fill_start = 1'b1;
        fill_addr = a;
        tick();
        fill_start = 1'b0;
        chk("start_busy", 64'(fill_busy), 64'd1);
    endtask

    initial begin
        tick();
        tick();
        chk("rst_rdata", cpu_rdata, 64'd0);
        chk("rst_rvalid", 64'(cpu_rvalid), 64'd0);
        chk("rst_busy", 64'(fill_busy), 64'd0);
        chk("rst_done", 64'(fill_done), 64'd0);
        gen_reset_n = 1'b1;
        rd(10'd0, 64'd0);
        rd(10'd5, 64'd0);
        rd(10'd1023, 64'd0);
        chk("idle_busy", 64'(fill_busy), 64'd0);

        wr(10'd5, 2'd2, 16'hBEEF);
        rd(10'd5, 64'h0000_BEEF_0000_0000);
        wr(10'd5, 2'd0, 16'h1234);
        rd(10'd5, 64'h0000_BEEF_0000_1234);
        tick();
        chk("rvalid_low", 64'(cpu_rvalid), 64'd0);
        chk("rdata_hold", cpu_rdata, 64'h0000_BEEF_0000_1234);

        // fill_valid in IDLE alongside fill_start must not be taken as a beat
        fill_valid = 1'b1;
        fill_data = 16'hFFFF;
        start(10'd9);
        cpu_we = 1'b1; cpu_addr = 10'd9; cpu_word_sel = 2'd1; cpu_wdata = 16'hAAAA;
        fstep(1'b1, 16'h1111, 1'b0);
        cpu_addr = 10'd7; cpu_word_sel = 2'd3; cpu_wdata = 16'h7777;
        fill_start = 1'b1; fill_addr = 10'd3;
        fstep(1'b1, 16'h2222, 1'b0);
        cpu_we = 1'b0;
        fill_start = 1'b0;
        cpu_re = 1'b1; cpu_addr = 10'd9; sb.push_back(64'd0);
        fstep(1'b0, 16'h0, 1'b0);
        cpu_re = 1'b0;
        fill_start = 1'b1; fill_addr = 10'd3;
        fstep(1'b0, 16'h0, 1'b0);
        fill_start = 1'b0;
        fstep(1'b1, 16'h3333, 1'b0);
        cpu_we = 1'b1; cpu_addr = 10'd9; cpu_word_sel = 2'd0; cpu_wdata = 16'hDEAD;
        cpu_re = 1'b1; sb.push_back(64'd0);
        fstep(1'b1, 16'h4444, 1'b1);
        cpu_we = 1'b0; cpu_re = 1'b0;
        fill_start = 1'b1; fill_addr = 10'd3;
        tick();
        fill_start = 1'b0;
        chk("post_done_busy", 64'(fill_busy), 64'd0);
        chk("post_done_pulse", 64'(fill_done), 64'd0);
        tick();
        chk("no_restart_busy", 64'(fill_busy), 64'd0);
        rd(10'd9, 64'h4444_3333_2222_1111);
        rd(10'd7, 64'h7777_0000_0000_0000);
        rd(10'd3, 64'd0);

        cpu_re = 1'b1; cpu_we = 1'b1; cpu_addr = 10'd5; cpu_word_sel = 2'd3; cpu_wdata = 16'hCAFE;
        sb.push_back(64'h0000_BEEF_0000_1234);
        tick();
        cpu_re = 1'b0; cpu_we = 1'b0;
        rd(10'd5, 64'hCAFE_BEEF_0000_1234);

        start(10'd12);
        fstep(1'b1, 16'h5555, 1'b0);
        fstep(1'b1, 16'h6666, 1'b0);
        gen_reset_n = 1'b0;
        fill_valid = 1'b1;
        fill_data = 16'h7777;
        tick();
        fill_valid = 1'b0;
        chk("rst_fill_busy", 64'(fill_busy), 64'd0);
        chk("rst_fill_done", 64'(fill_done), 64'd0);
        gen_reset_n = 1'b1;
        tick();
        tick();
        chk("abort_busy", 64'(fill_busy), 64'd0);
        chk("abort_done_cnt", 64'(done_cnt), 64'd1);
        rd(10'd12, 64'd0);
        rd(10'd9, 64'd0);

        start(10'd12);
        fstep(1'b1, 16'h0A0A, 1'b0);
        fstep(1'b1, 16'h0B0B, 1'b0);
        fstep(1'b1, 16'h0C0C, 1'b0);
        cpu_we = 1'b1; cpu_addr = 10'd20; cpu_word_sel = 2'd1; cpu_wdata = 16'h1357;
        fstep(1'b1, 16'h0D0D, 1'b1);
        cpu_we = 1'b0;
        tick();
        chk("refill_done_cnt", 64'(done_cnt), 64'd2);
        rd(10'd12, 64'h0D0D_0C0C_0B0B_0A0A);
        rd(10'd20, 64'h0000_0000_1357_0000);
        tick();
        tick();
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
